// File: rtl/mic_capture_pkg.sv
// Shared types and register bit positions for the microphone capture path.
package mic_capture_pkg;

    localparam int SAMPLE_W_DFLT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_e;

    typedef logic signed [SAMPLE_W_DFLT-1:0] sample_t;

    // Bit positions in the slave register block's CTRL and STAT words.
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;
    localparam int STAT_OVF_BIT    = 0;
    localparam int STAT_VALID_BIT  = 1;

endpackage

// File: rtl/mic_sample_fifo.sv
// First-word-fall-through sample FIFO with a sticky overflow flag and a
// synchronous clear. DEPTH must be a power of two and at least 2.
module mic_sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             empty, full, do_push, do_pop;

    // Handshake: a pop happens only when valid && pop are both high in the
    // same cycle; a push into a full FIFO succeeds only if a pop frees a slot.
    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == LW'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        head     = empty ? last_q : mem_q[rd_ptr_q];
        last_d   = head;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (push && !do_push) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            last_q   <= last_d;
        end
    end

    assign valid    = !empty;
    assign level    = level_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/mic_capture_ctrl.sv
// PDM microphone capture: clock divider, input synchroniser, ones-count
// decimator, warm-up FSM and sample FIFO. MIC_CAPTURE_IRQ_EN adds a level/overflow irq.
module mic_capture_ctrl
    import mic_capture_pkg::*;
#(
    parameter int CLK_DIV    = 25,
    parameter int DEC_LEN    = 64,
    parameter int WARMUP_WIN = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int SAMPLE_W   = SAMPLE_W_DFLT
`ifdef MIC_CAPTURE_IRQ_EN
    ,
    parameter int IRQ_THRESH = FIFO_DEPTH / 2
`endif
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        cfg_enable,
    input  logic                        cfg_clear,
    output logic                        pdm_clk,
    input  logic                        pdm_data,
    output logic                        rd_valid,
    output logic [SAMPLE_W-1:0]         rd_data,
    input  logic                        rd_ready,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overflow,
    output logic [1:0]                  state
`ifdef MIC_CAPTURE_IRQ_EN
    ,
    output logic                        irq
`endif
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DEC_LEN);
    localparam int OW = BW + 1;
    localparam int WW = $clog2(WARMUP_WIN + 1) + 1;

    state_e              state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic                pdm_clk_q, pdm_clk_d;
    logic                sync1_q, sync2_q;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [OW-1:0]       ones_q, ones_d;
    logic [WW-1:0]       win_q, win_d;
    logic                active, div_tc, strobe, win_done, push;
    logic [SAMPLE_W-1:0] sample;

    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cfg_enable) begin
                    if (WARMUP_WIN == 0) state_d = RUN;
                    else                 state_d = WARMUP;
                end
            end
            WARMUP: begin
                if (!cfg_enable) state_d = IDLE;
                else if (win_done && ((32'(win_q) + 32'd1) == WARMUP_WIN)) state_d = RUN;
            end
            RUN: begin
                if (!cfg_enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        state   = state_q;
        pdm_clk = pdm_clk_q;
    end

    // Everything is cleared the cycle enable is seen low, so a restart
    // always begins with a fresh divider phase and an empty window.
    always_comb begin
        active    = (state_q != IDLE) && cfg_enable;
        div_tc    = (div_q == DW'(CLK_DIV - 1));
        strobe    = active && div_tc && pdm_clk_q;
        win_done  = strobe && (bit_cnt_q == BW'(DEC_LEN - 1));
        sample    = SAMPLE_W'(ones_q) + SAMPLE_W'(sync2_q) - SAMPLE_W'(DEC_LEN / 2);
        push      = win_done && (state_q == RUN);
        div_d     = '0;
        pdm_clk_d = 1'b0;
        bit_cnt_d = '0;
        ones_d    = '0;
        win_d     = '0;
        if (active) begin
            div_d     = div_tc ? '0 : div_q + DW'(1);
            pdm_clk_d = pdm_clk_q ^ div_tc;
            bit_cnt_d = bit_cnt_q;
            ones_d    = ones_q;
            win_d     = win_q;
            if (win_done) begin
                bit_cnt_d = '0;
                ones_d    = '0;
                if (state_q == WARMUP) win_d = win_q + WW'(1);
            end else if (strobe) begin
                bit_cnt_d = bit_cnt_q + BW'(1);
                ones_d    = ones_q + OW'(sync2_q);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            div_q     <= '0;
            pdm_clk_q <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            bit_cnt_q <= '0;
            ones_q    <= '0;
            win_q     <= '0;
        end else begin
            div_q     <= div_d;
            pdm_clk_q <= pdm_clk_d;
            sync1_q   <= pdm_data;
            sync2_q   <= sync1_q;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            win_q     <= win_d;
        end
    end

    mic_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .clear     (cfg_clear),
        .push      (push),
        .push_data (sample),
        .pop       (rd_ready),
        .head      (rd_data),
        .valid     (rd_valid),
        .level     (level),
        .overflow  (overflow)
    );

`ifdef MIC_CAPTURE_IRQ_EN
    logic irq_q, irq_d;

    always_comb irq_d = (32'(level) >= IRQ_THRESH) || overflow;

    always_ff @(posedge ACLK) begin
        if (ARESET) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Directed bench for mic_capture_ctrl with CLK_DIV=2, DEC_LEN=8, WARMUP_WIN=1,
// FIFO_DEPTH=4; cycle numbers below count ACLK edges from the enabling edge.
module tb_mic_capture_ctrl;
    localparam int SW = 16;
    localparam int NV = 16;

    logic          ACLK = 1'b0;
    logic          ARESET, cfg_enable, cfg_clear, pdm_data, rd_ready;
    logic          pdm_clk, rd_valid, overflow;
    logic [SW-1:0] rd_data;
    logic [2:0]    level;
    logic [1:0]    state;
`ifdef MIC_CAPTURE_IRQ_EN
    logic          irq;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pdm_mode = 1;  // 0 constant 0, 1 constant 1, 2 alternate per strobe
    logic [SW-1:0] exp_q[$];

    typedef struct {
        int          cyc;
        logic [1:0]  st;
        logic        pclk;
        logic        vld;
        logic [2:0]  lvl;
        logic        ovf;
        logic [SW-1:0] dat;
        logic        irq;
        int          act;
    } vec_t;
    vec_t vecs[NV];

    mic_capture_ctrl #(
        .CLK_DIV    (2),
        .DEC_LEN    (8),
        .WARMUP_WIN (1),
        .FIFO_DEPTH (4),
        .SAMPLE_W   (SW)
`ifdef MIC_CAPTURE_IRQ_EN
        ,
        .IRQ_THRESH (2)
`endif
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .cfg_enable (cfg_enable),
        .cfg_clear  (cfg_clear),
        .pdm_clk    (pdm_clk),
        .pdm_data   (pdm_data),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .level      (level),
        .overflow   (overflow),
        .state      (state)
`ifdef MIC_CAPTURE_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    // Clock and reset block
    always #5 ACLK = ~ACLK;

    // Mic model: new bit presented just after each falling pdm_clk edge.
    initial begin
        forever begin
            @(negedge pdm_clk);
            #1;
            if (pdm_mode == 2) pdm_data = ~pdm_data;
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cyc %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_mode(input int mode, input logic bit_val);
        pdm_mode = mode;
        pdm_data = bit_val;
    endtask

    initial begin
        ARESET = 1'b1; cfg_enable = 1'b0; cfg_clear = 1'b0; rd_ready = 1'b0;
        pdm_data = 1'b1; pdm_mode = 1;

        //          cyc  st pclk vld lvl ovf dat        irq act
        vecs[0]  = '{0,   1, 0,  0,  0,  0,  16'h0000, 0,  0};
        vecs[1]  = '{1,   1, 0,  0,  0,  0,  16'h0000, 0,  0};
        vecs[2]  = '{2,   1, 1,  0,  0,  0,  16'h0000, 0,  0};
        vecs[3]  = '{3,   1, 1,  0,  0,  0,  16'h0000, 0,  0};
        vecs[4]  = '{4,   1, 0,  0,  0,  0,  16'h0000, 0,  0};
        vecs[5]  = '{6,   1, 1,  0,  0,  0,  16'h0000, 0,  0};
        vecs[6]  = '{31,  1, 1,  0,  0,  0,  16'h0000, 0,  0};
        vecs[7]  = '{32,  2, 0,  0,  0,  0,  16'h0000, 0,  0};
        vecs[8]  = '{63,  2, 1,  0,  0,  0,  16'h0000, 0,  0};
        vecs[9]  = '{64,  2, 0,  1,  1,  0,  16'h0004, 0,  0};
        vecs[10] = '{65,  2, 0,  1,  1,  0,  16'h0004, 0,  1};
        vecs[11] = '{96,  2, 0,  1,  2,  0,  16'h0004, 0,  0};
        vecs[12] = '{97,  2, 0,  1,  2,  0,  16'h0004, 1,  0};
        vecs[13] = '{160, 2, 0,  1,  4,  0,  16'h0004, 1,  0};
        vecs[14] = '{191, 2, 1,  1,  4,  0,  16'h0004, 1,  0};
        vecs[15] = '{192, 2, 0,  1,  4,  1,  16'h0004, 1,  0};

        repeat (3) tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pdm_clk", 32'(pdm_clk), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
`ifdef MIC_CAPTURE_IRQ_EN
        chk("rst_irq", 32'(irq), 32'd0);
`endif
        ARESET = 1'b0;
        tick();

        // Run 1: constant-1 warm-up and first sample, then alternating data fill to overflow
        cyc = -1;
        cfg_enable = 1'b1;
        for (int i = 0; i < NV; i++) begin
            tick_to(vecs[i].cyc);
            chk("tbl_state", 32'(state), 32'(vecs[i].st));
            chk("tbl_pdm_clk", 32'(pdm_clk), 32'(vecs[i].pclk));
            chk("tbl_valid", 32'(rd_valid), 32'(vecs[i].vld));
            chk("tbl_level", 32'(level), 32'(vecs[i].lvl));
            chk("tbl_ovf", 32'(overflow), 32'(vecs[i].ovf));
            chk("tbl_data", 32'(rd_data), 32'(vecs[i].dat));
`ifdef MIC_CAPTURE_IRQ_EN
            chk("tbl_irq", 32'(irq), 32'(vecs[i].irq));
`endif
            if (vecs[i].act == 1) set_mode(2, 1'b0);
        end

        // cfg_clear flushes FIFO and overflow, FSM keeps running
        tick_to(200);
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_valid", 32'(rd_valid), 32'd0);
        chk("clr_hold_data", 32'(rd_data), 32'h0004);
        chk("clr_state", 32'(state), 32'd2);
`ifdef MIC_CAPTURE_IRQ_EN
        tick();
        chk("clr_irq", 32'(irq), 32'd0);
`endif

        // Refill with distinct samples: 0 (alt), -4, +4, 0, then -4 pushed during a pop
        tick_to(225); set_mode(0, 1'b0);
        tick_to(256);
        chk("s7_level", 32'(level), 32'd2);
        tick_to(257); set_mode(1, 1'b1);
        tick_to(289); set_mode(2, 1'b0);
        tick_to(320);
        chk("full_level", 32'(level), 32'd4);
        chk("full_head", 32'(rd_data), 32'h0000);
        tick_to(321); set_mode(0, 1'b0);
        tick_to(351);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("pushpop_level", 32'(level), 32'd4);
        chk("pushpop_ovf", 32'(overflow), 32'd0);

        exp_q.push_back(16'hFFFC);
        exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'hFFFC);
        while (exp_q.size() > 0) begin
            chk("pop_valid", 32'(rd_valid), 32'd1);
            chk("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
`ifdef MIC_CAPTURE_IRQ_EN
            if (cyc == 355) chk("irq_hold", 32'(irq), 32'd1);
`endif
        end
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_valid", 32'(rd_valid), 32'd0);
        chk("drain_hold_data", 32'(rd_data), 32'hFFFC);
`ifdef MIC_CAPTURE_IRQ_EN
        chk("irq_fall", 32'(irq), 32'd0);
`endif

        // Drop enable after 3 bits of a window, while pdm_clk is high
        tick_to(366);
        chk("pre_drop_pdm_clk", 32'(pdm_clk), 32'd1);
        cfg_enable = 1'b0;
        tick();
        chk("drop_state", 32'(state), 32'd0);
        chk("drop_pdm_clk", 32'(pdm_clk), 32'd0);
        repeat (40) tick();
        chk("drop_no_push", 32'(level), 32'd0);
        chk("drop_pdm_idle", 32'(pdm_clk), 32'd0);

        // Re-enable: full warm-up again and a fresh 8-bit window
        cyc = -1;
        cfg_enable = 1'b1;
        tick_to(0);
        chk("re_state0", 32'(state), 32'd1);
        tick_to(2);
        chk("re_pdm_rise", 32'(pdm_clk), 32'd1);
        tick_to(31);
        chk("re_warm", 32'(state), 32'd1);
        tick_to(32);
        chk("re_run", 32'(state), 32'd2);
        tick_to(63);
        chk("re_valid_early", 32'(rd_valid), 32'd0);
        tick_to(64);
        chk("re_valid", 32'(rd_valid), 32'd1);
        chk("re_level", 32'(level), 32'd1);
        chk("re_data", 32'(rd_data), 32'hFFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mic_capture_ctrl.md
Name: mic_capture_ctrl

Overview:
Capture sequencer for the microphone peripheral.
- Generates the PDM microphone clock and synchronises and samples the PDM bit stream.
- Decimates the stream by ones-counting over fixed windows and discards warm-up windows after enable.
- Buffers signed samples in a small first-word-fall-through (FWFT) FIFO read by the AXI4-Lite register file.
- Sits between the mic pins and the slave register block; the register block drives cfg_* and pops rd_*.

Parameters:
- CLK_DIV, 25: ACLK cycles per pdm_clk half-period (pdm_clk = ACLK/(2*CLK_DIV)); legal range >=1.
- DEC_LEN, 64: PDM bits per output sample; power of two, 4..256.
- WARMUP_WIN, 4: windows discarded after entering WARMUP; 0 means go straight to RUN.
- FIFO_DEPTH, 16: sample FIFO entries; power of two.
- SAMPLE_W, 16: output sample width, signed.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous reset, active-high
- cfg_enable  in  1  level; 1 = capture
- cfg_clear  in  1  single-cycle pulse; flush FIFO, clear overflow
- pdm_clk  out  1  microphone clock
- pdm_data  in  1  asynchronous mic data
- rd_valid  out  1  FIFO non-empty
- rd_data  out  SAMPLE_W  FIFO head sample
- rd_ready  in  1  pop when rd_valid&&rd_ready
- level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky; a sample was dropped
- state  out  2  FSM state encoding

Behaviour:
- Reset (ARESET=1 at a rising ACLK edge): state=IDLE, pdm_clk=0, rd_valid=0, rd_data=0, level=0, overflow=0. Divider, bit and window counters, accumulator and synchroniser are cleared.
- FSM encoding: IDLE=0, WARMUP=1, RUN=2.
  - IDLE -> WARMUP when cfg_enable=1 (or -> RUN if WARMUP_WIN=0).
  - WARMUP -> RUN after WARMUP_WIN complete windows.
  - Any state -> IDLE on the cycle after cfg_enable is seen low. The partial window is discarded; FIFO contents are kept.
  - Re-enable restarts with a full warm-up.
- Clock divider:
  - In IDLE, the divider is held at 0 and pdm_clk=0.
  - Otherwise the divider counts 0..CLK_DIV-1; on terminal count pdm_clk toggles and the divider wraps to 0.
  - The first rising pdm_clk edge occurs CLK_DIV cycles after leaving IDLE.
- Sampling:
  - pdm_data passes through a 2-flop synchroniser.
  - Sample strobe = the ACLK cycle in which the divider commands the 1->0 pdm_clk toggle (falling edge).
  - The strobe captures the synchronised bit.
- Decimation:
  - The ones counter accumulates over DEC_LEN strobes.
  - At the last strobe, sample = ones + current bit - DEC_LEN/2, sign-extended to SAMPLE_W. Range is -DEC_LEN/2..+DEC_LEN/2.
  - The accumulator and bit counter restart at 0 in that same cycle.
- Push:
  - Only in RUN.
  - The sample is written at the edge following the last strobe; rd_valid and level reflect it in that same next cycle (1-cycle latency).
- FIFO:
  - FWFT; rd_data is the head, combinational from storage.
  - Pop on rd_valid&&rd_ready.
  - Empty: rd_valid=0, and rd_data holds its last value.
- Full:
  - Push without a simultaneous pop: the sample is dropped, overflow is set, level stays FIFO_DEPTH.
  - Push and pop in the same cycle when full: both succeed and level is unchanged.
- cfg_clear:
  - level=0, pointers=0, overflow=0 next cycle.
  - Overrides any push/pop in the same cycle.
  - FSM and window state are unaffected.
- Pointer wrap: natural modulo FIFO_DEPTH; level uses an extra bit to distinguish full from empty.

Optional Feature:
- Macro: MIC_CAPTURE_IRQ_EN.
- Defined:
  - Adds parameter IRQ_THRESH (default FIFO_DEPTH/2) and output port irq (1 bit, registered, reset 0).
  - irq=1 while level >= IRQ_THRESH or overflow=1.
  - irq updates one cycle after level/overflow change.
- Undefined: no irq port and no threshold logic; all other behaviour is identical.

Decomposition:
- Package mic_capture_pkg contains:
  - state_e enum (IDLE/WARMUP/RUN, 2-bit).
  - sample_t typedef (logic signed [SAMPLE_W-1:0]).
  - Register bit-index constants: CTRL_ENABLE_BIT=0, CTRL_CLEAR_BIT=1, STAT_OVF_BIT=0, STAT_VALID_BIT=1.
- One sub-module, mic_sample_fifo: parameterised FWFT FIFO with push, pop, clear, level and overflow.
- The divider, synchroniser, decimator and FSM stay in the top module.

Test Plan:
- Reset then enable, with CLK_DIV=2, DEC_LEN=8, WARMUP_WIN=1, pdm_data=1: first pdm_clk rise 2 cycles after enable; period 4 ACLK cycles; state 1->2 after 32 cycles. First pushed sample = +4; rd_valid rises 1 cycle after the 16th falling-edge strobe.
- pdm_data alternating 1,0 per strobe with DEC_LEN=8 -> every sample 0; pdm_data=0 constant -> every sample -4 (0xFFFC).
- rd_ready=0 with FIFO_DEPTH=4 -> level reaches 4; the 5th window is dropped; overflow=1; the head is still the 1st sample. Then pulse cfg_clear -> level=0 and overflow=0 next cycle.
- Full FIFO with rd_ready=1 held across a push cycle -> level stays 4, no overflow, popped order preserved.
- Drop cfg_enable mid-window (after 3 of 8 bits) -> state=0 next cycle, pdm_clk=0, no push; re-enable repeats the full warm-up, and the next sample uses exactly 8 new bits.
- With MIC_CAPTURE_IRQ_EN and IRQ_THRESH=2: irq rises 1 cycle after level reaches 2, and falls 1 cycle after a pop takes level to 1.
